// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then collects FRAME_BYTES
// data bytes, each followed by an even-parity bit, from a strobed bit stream.
module serial_frame_rx #(
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         FRAME_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       din,
    input  logic       din_en,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       par_err,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    state_t     state;
    logic [7:0] win;
    logic [7:0] data;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic       strobe;
    logic [7:0] win_next;

    // A bit is consumed only when din_en and ena are both high on a rising
    // edge; there is no back-pressure, so every such bit must be taken.
    assign strobe   = din_en & ena;
    assign win_next = {win[6:0], din};
    assign state_o  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            win        <= 8'h00;
            data       <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 4'd0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
            if (strobe) begin
                case (state)
                    HUNT: begin
                        if (win_next == SYNC) begin
                            state    <= DATA;
                            win      <= 8'h00;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 4'd0;
                        end else begin
                            win <= win_next;
                        end
                    end
                    DATA: begin
                        data    <= {data[6:0], din};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        // Even parity: the byte plus its parity bit XOR to zero.
                        if ((^data) == din) begin
                            byte_out   <= data;
                            byte_valid <= 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                frame_done <= 1'b1;
                                state      <= HUNT;
                                win        <= 8'h00;
                                byte_cnt   <= 4'd0;
                            end else begin
                                state    <= DATA;
                                bit_cnt  <= 3'd0;
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end else begin
                            par_err  <= 1'b1;
                            state    <= HUNT;
                            win      <= 8'h00;
                            byte_cnt <= 4'd0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: fixed vector table, corner sequences and random
// bit streams checked against a stream-level frame parser.
module tb_serial_frame_rx;

    localparam logic [7:0] SYNC        = 8'hA5;
    localparam int         FRAME_BYTES = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       din;
    logic       din_en;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_done;
    logic       par_err;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Events are {frame_done, par_err, byte_valid, byte_out}.
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic        stream_q[$];
    logic [7:0]  model_last;

    typedef struct {
        logic        sync;
        logic [7:0]  d;
        logic        p;
        logic [10:0] exp_ev;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[7];

    serial_frame_rx #(.SYNC(SYNC), .FRAME_BYTES(FRAME_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din),
        .din_en    (din_en),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .frame_done(frame_done),
        .par_err   (par_err),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (byte_valid || frame_done || par_err)
            obs_q.push_back({frame_done, par_err, byte_valid, byte_out});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        if (ena) stream_q.push_back(b);
        @(negedge clk);
        din_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int k = 7; k >= 0; k--) begin
            send_bit(v[k]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_bit_r(input logic b);
        if ($urandom_range(0, 7) == 0) begin
            ena    = 1'b0;
            din_en = 1'b1;
            din    = 1'($urandom);
            @(negedge clk);
            ena    = 1'b1;
            din_en = 1'b0;
        end
        send_bit(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Parses the accepted bit stream into frames from scratch: a sync match
    // needs 8 fresh bits, then each byte is 8 data bits plus an even-parity bit.
    task automatic model_run();
        int          pos = 0;
        int          n = stream_q.size();
        int          j;
        logic [7:0]  w;
        logic [7:0]  d;
        logic        p;
        bit          found;
        while (pos < n) begin
            found = 1'b0;
            for (j = pos + 7; j < n; j++) begin
                w = 8'h00;
                for (int k = 0; k < 8; k++) w = {w[6:0], stream_q[j - 7 + k]};
                if (w == SYNC) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            pos = j + 1;
            for (int b = 0; b < FRAME_BYTES; b++) begin
                if (pos + 9 > n) begin
                    pos = n;
                    break;
                end
                d = 8'h00;
                for (int k = 0; k < 8; k++) d = {d[6:0], stream_q[pos + k]};
                p = stream_q[pos + 8];
                pos += 9;
                if (((^d) ^ p) != 1'b0) begin
                    exp_q.push_back({3'b010, model_last});
                    break;
                end
                model_last = d;
                exp_q.push_back({(b == FRAME_BYTES - 1), 2'b01, d});
            end
        end
    endtask

    task automatic finish_segment(input string name);
        int n;
        repeat (3) @(negedge clk);
        model_run();
        check($sformatf("%s_event_count", name), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_event%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        obs_q.delete();
        stream_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst_n  = 1'b0;
        din_en = 1'b1;
        din    = 1'($urandom);
        repeat (cycles) @(negedge clk);
        check("rst_byte_out", 32'(byte_out), 32'h0);
        check("rst_byte_valid", 32'(byte_valid), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        rst_n      = 1'b1;
        din_en     = 1'b0;
        model_last = 8'h00;
        stream_q.delete();
    endtask

    task automatic run_table(input int gap);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].sync) send_byte(SYNC, gap);
            send_byte(vecs[i].d, gap);
            send_bit(vecs[i].p);
            check($sformatf("vec%0d_gap%0d_event", i, gap),
                  32'({frame_done, par_err, byte_valid, byte_out}), 32'(vecs[i].exp_ev));
            check($sformatf("vec%0d_gap%0d_state", i, gap), 32'(state_o), 32'(vecs[i].exp_state));
            repeat (gap) @(negedge clk);
        end
        finish_segment($sformatf("table_gap%0d", gap));
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h12, 1'b0, {3'b001, 8'h12}, 2'd1};
        vecs[1] = '{1'b0, 8'h34, 1'b1, {3'b001, 8'h34}, 2'd1};
        vecs[2] = '{1'b0, 8'h56, 1'b0, {3'b001, 8'h56}, 2'd1};
        vecs[3] = '{1'b0, 8'h78, 1'b0, {3'b101, 8'h78}, 2'd0};
        vecs[4] = '{1'b1, 8'h0F, 1'b1, {3'b010, 8'h78}, 2'd0};
        vecs[5] = '{1'b1, 8'hA5, 1'b0, {3'b001, 8'hA5}, 2'd1};
        vecs[6] = '{1'b0, 8'hA5, 1'b0, {3'b001, 8'hA5}, 2'd1};

        rst_n      = 1'b0;
        ena        = 1'b1;
        din        = 1'b0;
        din_en     = 1'b0;
        model_last = 8'h00;
        @(negedge clk);
        do_reset(2);

        run_table(0);
        do_reset(2);
        run_table(3);
        do_reset(1);

        // Sync slip: leading 1,0 must not disturb detection of the real sync.
        send_bit(1'b1);
        send_bit(1'b0);
        send_byte(SYNC, 0);
        send_byte(8'hC3, 0);
        send_bit(1'b0);
        check("slip_byte_out", 32'(byte_out), 32'hC3);
        check("slip_byte_valid", 32'(byte_valid), 32'h1);
        finish_segment("slip");
        do_reset(1);

        // Reset in the middle of the second byte, then a full clean frame.
        send_byte(SYNC, 0);
        send_byte(8'h12, 0);
        send_bit(1'b0);
        for (int k = 7; k >= 4; k--) send_bit(vecs[1].d[k]);
        finish_segment("rst_mid_pre");
        do_reset(2);
        send_byte(SYNC, 0);
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].d, 0);
            send_bit(vecs[i].p);
        end
        check("rst_mid_frame_done", 32'(frame_done), 32'h1);
        finish_segment("rst_mid_post");
        do_reset(1);

        // ena low with strobes mid-byte: nothing may move.
        send_byte(SYNC, 0);
        for (int k = 7; k >= 4; k--) send_bit(1'((8'h5A >> k) & 8'h01));
        ena = 1'b0;
        for (int c = 0; c < 10; c++) begin
            din    = 1'($urandom);
            din_en = 1'b1;
            @(negedge clk);
        end
        check("ena_low_state", 32'(state_o), 32'h1);
        ena    = 1'b1;
        din_en = 1'b0;
        for (int k = 3; k >= 0; k--) send_bit(1'((8'h5A >> k) & 8'h01));
        send_bit(1'b0);
        check("ena_byte", 32'({frame_done, par_err, byte_valid, byte_out}), 32'({3'b001, 8'h5A}));
        finish_segment("ena");
        do_reset(1);

        for (int s = 0; s < 40; s++) begin
            logic [7:0] d;
            int         nb;
            repeat ($urandom_range(0, 12)) send_bit_r(1'($urandom));
            if ($urandom_range(0, 3) != 0)
                for (int k = 7; k >= 0; k--) send_bit_r(SYNC[k]);
            nb = $urandom_range(1, FRAME_BYTES + 2);
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                for (int k = 7; k >= 0; k--) send_bit_r(d[k]);
                send_bit_r((^d) ^ ($urandom_range(0, 7) == 0));
            end
            finish_segment($sformatf("rand%0d", s));
            do_reset(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
